mesh_hs_monitor: RTL and testbench
==================================

Name: mesh_hs_monitor

Overview:
- Synthesizable, parametrised per-terminal handshake monitor for the mesh router's pndng/pop interface.
- One instance watches every terminal's outbound pndng/pop pair in parallel.
- Per channel it measures pndng-rise to pop-rise latency against a configurable window and flags timeout, early, drop and spurious-pop violations with sticky bits.
- Keeps saturating pass counters and a maximum-observed latency per channel for end-of-test reporting. It sits beside the DUT in the environment and in emulation builds.

Parameters:
- CHANNELS, 16, number of monitored terminals.
- MIN_LAT, 1, minimum legal latency in cycles, 0 to MAX_LAT.
- MAX_LAT, 10, maximum legal latency in cycles, at least 1 and below 2^LAT_W.
- LAT_W, 8, latency counter and max-latency field width.
- CNT_W, 16, pass counter width.
- PCKG_SZ, 40, packet width; used only with DATA_STABLE_EN.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of sticky flags, counters and max latency; FSMs are not affected.
- pndng  in  CHANNELS  per-channel pending.
- pop  in  CHANNELS  per-channel pop.
- data_out  in  CHANNELS*PCKG_SZ  per-channel data, channel i at [i*PCKG_SZ +: PCKG_SZ]; ignored unless DATA_STABLE_EN.
- err_timeout  out  CHANNELS  sticky, no pop by MAX_LAT.
- err_early  out  CHANNELS  sticky, pop rose with latency below MIN_LAT.
- err_drop  out  CHANNELS  sticky, pndng fell before pop rose.
- err_spur  out  CHANNELS  sticky, pop rose while channel IDLE.
- err_any  out  1  OR of all sticky error bits.
- pass_cnt  out  CHANNELS*CNT_W  per-channel count of in-window handshakes.
- lat_max  out  CHANNELS*LAT_W  per-channel largest passing latency.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, all FSMs IDLE, pndng_q=0, pop_q=0, lat=0.
- Edge detect per channel:
  - rise_p = pndng & ~pndng_q
  - fall_p = ~pndng & pndng_q
  - rise_o = pop & ~pop_q
  - pndng_q and pop_q are registered every cycle.
- Latency L is the number of cycles from the rise_p cycle to the rise_o cycle.
- FSM per channel, two states, IDLE and WAIT. Events are evaluated in this priority order:
  - IDLE, rise_p & rise_o (L=0): if MIN_LAT=0, count a pass with lat_max candidate 0; otherwise set err_early. Stay IDLE.
  - IDLE, rise_p only: go to WAIT, lat<=1.
  - IDLE, rise_o without rise_p: set err_spur.
  - WAIT, rise_o:
    - if MIN_LAT<=lat<=MAX_LAT: pass_cnt+=1 (saturating at all-ones); lat_max<=max(lat_max, lat).
    - if lat<MIN_LAT: set err_early.
    - In both cases go to IDLE.
  - WAIT, fall_p without rise_o: set err_drop, go to IDLE.
  - WAIT, lat==MAX_LAT, no rise_o: set err_timeout, go to IDLE. A later pop rise is then flagged err_spur.
  - WAIT otherwise: lat+=1.
- pndng held high across consecutive packets is not re-armed; only a new pndng rise starts a measurement.
- Flags, counters and lat_max update on the clock edge after the event cycle (1-cycle latency). err_any is combinational from the registered flags.
- clr=1: flags, pass_cnt and lat_max go to 0 next edge. clr takes priority over a same-cycle set or increment.
- Reset asserted mid-WAIT: the channel returns to IDLE with no flag set. The pre-reset pndng level is forgotten, so pndng held high through reset release counts as a rise on the first cycle after release.
- Channels are fully independent; no shared arbitration.

Optional Feature:
- Macro MESH_HS_DATA_STABLE_EN.
- Defined:
  - adds output err_data (CHANNELS, sticky, cleared by clr, 0 at reset);
  - the rise_p cycle's data_out is captured per channel;
  - any WAIT cycle before rise_o in which data_out differs from the capture sets err_data the following edge.
- Undefined: no capture registers, no err_data port, data_out unused.

Test Plan (CHANNELS=4, MIN_LAT=1, MAX_LAT=10, LAT_W=8, CNT_W=16):
- ch0 pndng rises, pop rises 3 cycles later -> pass_cnt[0]=1, lat_max[0]=3, all err 0.
- ch1 pndng rises, held high, no pop for 11 cycles -> err_timeout[1]=1 one edge after lat=10; a pop rise at cycle 12 -> err_spur[1]=1.
- ch2 pndng and pop rise in the same cycle -> err_early[2]=1, pass_cnt[2]=0. Rerun with MIN_LAT=0 -> pass_cnt[2]=1, lat_max[2]=0.
- ch3 pndng rises, falls after 2 cycles without pop -> err_drop[3]=1, err_any=1. Then clr pulse -> all flags 0, err_any=0.
- ch0 latencies 2, 7, 5 -> pass_cnt[0]=3, lat_max[0]=7. reset=0 during a 4th WAIT -> all outputs 0 and no flag after release.
- MESH_HS_DATA_STABLE_EN defined: ch0 data_out changes 0x1 to 0x2 at lat=2, pop at lat=4 -> err_data[0]=1, pass_cnt[0]=1.

Source files
------------

// File: rtl/mesh_hs_monitor.sv
// mesh_hs_monitor: per-terminal pndng/pop handshake monitor for the mesh router.
// Each channel measures pndng-rise to pop-rise latency against [MIN_LAT, MAX_LAT].
// It flags timeout, early, drop and spurious-pop violations with sticky bits.
// It also keeps a saturating pass counter and the largest passing latency.
// Optional feature: define MESH_HS_DATA_STABLE_EN to add err_data. That flag
// catches data_out changing while a channel waits for its pop.
module mesh_hs_monitor #(
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned MIN_LAT  = 1,
  parameter int unsigned MAX_LAT  = 10,
  parameter int unsigned LAT_W    = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PCKG_SZ  = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic [CHANNELS-1:0]         pndng,
  input  logic [CHANNELS-1:0]         pop,
  input  logic [CHANNELS*PCKG_SZ-1:0] data_out,
  output logic [CHANNELS-1:0]         err_timeout,
  output logic [CHANNELS-1:0]         err_early,
  output logic [CHANNELS-1:0]         err_drop,
  output logic [CHANNELS-1:0]         err_spur,
`ifdef MESH_HS_DATA_STABLE_EN
  output logic [CHANNELS-1:0]         err_data,
`endif
  output logic                        err_any,
  output logic [CHANNELS*CNT_W-1:0]   pass_cnt,
  output logic [CHANNELS*LAT_W-1:0]   lat_max
);

  localparam int unsigned LW1         = LAT_W + 1;
  localparam logic        ZERO_LAT_OK = (MIN_LAT == 0);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  logic [CHANNELS-1:0] pndng_q;
  logic [CHANNELS-1:0] pop_q;

`ifndef MESH_HS_DATA_STABLE_EN
  logic unused_data;
  assign unused_data = ^data_out;
`endif

  // Previous-cycle levels for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pndng_q <= '0;
      pop_q   <= '0;
    end else begin
      pndng_q <= pndng;
      pop_q   <= pop;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             rise_p, fall_p, rise_o;
    logic             lat_lo_ok, lat_at_max;
    logic             ev_pass, ev_early, ev_spur, ev_drop, ev_timeout;
    logic [LAT_W-1:0] ev_lat;
    logic             f_timeout, f_early, f_drop, f_spur;
    logic [CNT_W-1:0] cnt_q;
    logic [LAT_W-1:0] lmax_q;

    assign rise_p     = pndng[i] & ~pndng_q[i];
    assign fall_p     = ~pndng[i] & pndng_q[i];
    assign rise_o     = pop[i] & ~pop_q[i];
    // lat >= MIN_LAT, written as lat+1 > MIN_LAT so MIN_LAT=0 is not a constant compare
    assign lat_lo_ok  = ({1'b0, lat_q} + LW1'(1)) > LW1'(MIN_LAT);
    assign lat_at_max = (lat_q == LAT_W'(MAX_LAT));

    // FSM state and latency counter register
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= S_IDLE;
        lat_q   <= '0;
      end else begin
        state_q <= state_d;
        lat_q   <= lat_d;
      end
    end

    // Next-state and latency counting
    always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      case (state_q)
        S_IDLE: begin
          if (rise_p && !rise_o) begin
            state_d = S_WAIT;
            lat_d   = LAT_W'(1);
          end
        end
        S_WAIT: begin
          if (rise_o || fall_p || lat_at_max) state_d = S_IDLE;
          else                                lat_d   = lat_q + LAT_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Per-cycle handshake events, in priority order
    always_comb begin
      ev_pass    = 1'b0;
      ev_early   = 1'b0;
      ev_spur    = 1'b0;
      ev_drop    = 1'b0;
      ev_timeout = 1'b0;
      ev_lat     = '0;
      case (state_q)
        S_IDLE: begin
          if (rise_p && rise_o) begin
            if (ZERO_LAT_OK) ev_pass  = 1'b1;
            else             ev_early = 1'b1;
          end else if (rise_o) begin
            ev_spur = 1'b1;
          end
        end
        S_WAIT: begin
          if (rise_o) begin
            ev_lat = lat_q;
            if (lat_lo_ok) ev_pass  = 1'b1;
            else           ev_early = 1'b1;
          end else if (fall_p) begin
            ev_drop = 1'b1;
          end else if (lat_at_max) begin
            ev_timeout = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Sticky flags, saturating pass counter and max latency; clr wins
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        f_timeout <= 1'b0;
        f_early   <= 1'b0;
        f_drop    <= 1'b0;
        f_spur    <= 1'b0;
        cnt_q     <= '0;
        lmax_q    <= '0;
      end else if (clr) begin
        f_timeout <= 1'b0;
        f_early   <= 1'b0;
        f_drop    <= 1'b0;
        f_spur    <= 1'b0;
        cnt_q     <= '0;
        lmax_q    <= '0;
      end else begin
        if (ev_timeout) f_timeout <= 1'b1;
        if (ev_early)   f_early   <= 1'b1;
        if (ev_drop)    f_drop    <= 1'b1;
        if (ev_spur)    f_spur    <= 1'b1;
        if (ev_pass) begin
          if (cnt_q != '1)      cnt_q  <= cnt_q + CNT_W'(1);
          if (ev_lat > lmax_q)  lmax_q <= ev_lat;
        end
      end
    end

    assign err_timeout[i]               = f_timeout;
    assign err_early[i]                 = f_early;
    assign err_drop[i]                  = f_drop;
    assign err_spur[i]                  = f_spur;
    assign pass_cnt[i*CNT_W +: CNT_W]   = cnt_q;
    assign lat_max[i*LAT_W +: LAT_W]    = lmax_q;

`ifdef MESH_HS_DATA_STABLE_EN
    logic [PCKG_SZ-1:0] cap_q;
    logic               ev_data;
    logic               f_data;

    assign ev_data = (state_q == S_WAIT) && !rise_o &&
                     (data_out[i*PCKG_SZ +: PCKG_SZ] != cap_q);

    // Capture the packet presented on the pndng rise
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          cap_q <= '0;
      else if (state_q == S_IDLE && rise_p) cap_q <= data_out[i*PCKG_SZ +: PCKG_SZ];
    end

    // Sticky data-stability flag
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)       f_data <= 1'b0;
      else if (clr)     f_data <= 1'b0;
      else if (ev_data) f_data <= 1'b1;
    end

    assign err_data[i] = f_data;
`endif
  end

`ifdef MESH_HS_DATA_STABLE_EN
  assign err_any = |{err_timeout, err_early, err_drop, err_spur, err_data};
`else
  assign err_any = |{err_timeout, err_early, err_drop, err_spur};
`endif

endmodule

// File: tb/tb_mesh_hs_monitor.sv
// Bench for mesh_hs_monitor: table of handshake transactions plus hand sequences.
// dut_a uses MIN_LAT=1 and dut_z uses MIN_LAT=0; both share the same stimulus.
module tb_mesh_hs_monitor;

  localparam int unsigned CH = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned PS = 40;

  logic clk = 1'b0;
  logic reset, clr;
  logic [CH-1:0]    pndng, pop;
  logic [CH*PS-1:0] data_out;

  logic [CH-1:0]    to_a, ea_a, dr_a, sp_a, to_z, ea_z, dr_z, sp_z;
  logic             any_a, any_z;
  logic [CH*CW-1:0] pc_a, pc_z;
  logic [CH*LW-1:0] lm_a, lm_z;
`ifdef MESH_HS_DATA_STABLE_EN
  logic [CH-1:0]    dt_a, dt_z;
`endif

  int checks = 0;
  int failures = 0;

  mesh_hs_monitor #(.CHANNELS(CH), .MIN_LAT(1), .MAX_LAT(10), .LAT_W(LW), .CNT_W(CW), .PCKG_SZ(PS)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .pndng(pndng), .pop(pop), .data_out(data_out),
    .err_timeout(to_a), .err_early(ea_a), .err_drop(dr_a), .err_spur(sp_a),
`ifdef MESH_HS_DATA_STABLE_EN
    .err_data(dt_a),
`endif
    .err_any(any_a), .pass_cnt(pc_a), .lat_max(lm_a));

  mesh_hs_monitor #(.CHANNELS(CH), .MIN_LAT(0), .MAX_LAT(10), .LAT_W(LW), .CNT_W(CW), .PCKG_SZ(PS)) dut_z (
    .clk(clk), .reset(reset), .clr(clr), .pndng(pndng), .pop(pop), .data_out(data_out),
    .err_timeout(to_z), .err_early(ea_z), .err_drop(dr_z), .err_spur(sp_z),
`ifdef MESH_HS_DATA_STABLE_EN
    .err_data(dt_z),
`endif
    .err_any(any_z), .pass_cnt(pc_z), .lat_max(lm_z));

  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // kind: 0 = pop rises n cycles after pndng, 1 = pndng falls after n cycles
  typedef struct {
    int       ch;
    int       kind;
    int       n;
    int       pass_a;
    int       lmax_a;
    logic [3:0] fl_a;   // {spur, drop, early, timeout}
    int       pass_z;
    int       lmax_z;
    logic [3:0] fl_z;
    logic     any_a;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] fl(input logic [CH-1:0] sp, input logic [CH-1:0] dr,
                                    input logic [CH-1:0] ea, input logic [CH-1:0] to, input int c);
    return {sp[c], dr[c], ea[c], to[c]};
  endfunction

  task automatic do_hs(input int c, input int kind, input int n);
    pndng[c] = 1'b1;
    if (kind == 0 && n == 0) pop[c] = 1'b1;
    tick();
    for (int k = 1; k <= n; k++) begin
      if (k == n) begin
        if (kind == 0) pop[c] = 1'b1;
        else           pndng[c] = 1'b0;
      end
      tick();
    end
    pndng[c] = 1'b0;
    pop[c]   = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_row(input int r);
    vec_t v;
    v = tbl[r];
    do_hs(v.ch, v.kind, v.n);
    chk($sformatf("row%0d pass_a", r), 64'(pc_a[v.ch*CW +: CW]), 64'(v.pass_a));
    chk($sformatf("row%0d lmax_a", r), 64'(lm_a[v.ch*LW +: LW]), 64'(v.lmax_a));
    chk($sformatf("row%0d flags_a", r), 64'(fl(sp_a, dr_a, ea_a, to_a, v.ch)), 64'(v.fl_a));
    chk($sformatf("row%0d pass_z", r), 64'(pc_z[v.ch*CW +: CW]), 64'(v.pass_z));
    chk($sformatf("row%0d lmax_z", r), 64'(lm_z[v.ch*LW +: LW]), 64'(v.lmax_z));
    chk($sformatf("row%0d flags_z", r), 64'(fl(sp_z, dr_z, ea_z, to_z, v.ch)), 64'(v.fl_z));
    chk($sformatf("row%0d any_a", r), 64'(any_a), 64'(v.any_a));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " pass_cnt"}, pc_a, 64'd0);
    chk({nm, " lat_max"}, 64'(lm_a), 64'd0);
    chk({nm, " flags"}, 64'({sp_a, dr_a, ea_a, to_a}), 64'd0);
    chk({nm, " err_any"}, 64'(any_a), 64'd0);
`ifdef MESH_HS_DATA_STABLE_EN
    chk({nm, " err_data"}, 64'(dt_a), 64'd0);
`endif
  endtask

  initial begin
    tbl[0] = '{0, 0, 3,  1, 3,  4'h0, 1, 3,  4'h0, 1'b0};
    tbl[1] = '{2, 0, 0,  0, 0,  4'h2, 1, 0,  4'h0, 1'b1};
    tbl[2] = '{3, 1, 2,  0, 0,  4'h4, 0, 0,  4'h4, 1'b1};
    tbl[3] = '{1, 0, 10, 1, 10, 4'h0, 1, 10, 4'h0, 1'b1};
    tbl[4] = '{0, 0, 2,  1, 2,  4'h0, 1, 2,  4'h0, 1'b0};
    tbl[5] = '{0, 0, 7,  2, 7,  4'h0, 2, 7,  4'h0, 1'b0};
    tbl[6] = '{0, 0, 5,  3, 7,  4'h0, 3, 7,  4'h0, 1'b0};
    tbl[7] = '{3, 0, 1,  1, 1,  4'h0, 1, 1,  4'h0, 1'b0};

    reset = 1'b0; clr = 1'b0; pndng = '0; pop = '0; data_out = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    for (int r = 0; r < 4; r++) run_row(r);

    // clr wipes everything on both instances
    chk("pre-clr any_a", 64'(any_a), 64'd1);
    chk("pre-clr any_z", 64'(any_z), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_all_zero("post-clr");
    chk("post-clr pass_z", pc_z, 64'd0);
    chk("post-clr any_z", 64'(any_z), 64'd0);

    // clr beats a same-cycle early flag (dut_a) and pass increment (dut_z)
    pndng[2] = 1'b1; pop[2] = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; pndng[2] = 1'b0; pop[2] = 1'b0;
    tick();
    chk("clr-prio early_a", 64'(ea_a[2]), 64'd0);
    chk("clr-prio pass_z", 64'(pc_z[2*CW +: CW]), 64'd0);

    for (int r = 4; r < 8; r++) run_row(r);

    // ch1 timeout after lat=10, then a late pop is spurious
    pndng[1] = 1'b1;
    tick();
    repeat (9) tick();
    chk("timeout not yet", 64'(to_a[1]), 64'd0);
    tick();
    chk("timeout set", 64'(to_a[1]), 64'd1);
    chk("spur not yet", 64'(sp_a[1]), 64'd0);
    tick();
    pop[1] = 1'b1;
    tick();
    chk("spur set", 64'(sp_a[1]), 64'd1);
    chk("timeout pass1", 64'(pc_a[1*CW +: CW]), 64'd0);
    pndng[1] = 1'b0; pop[1] = 1'b0;
    tick();

    // reset mid-WAIT on ch0; held pndng re-arms after release
    pndng[0] = 1'b1;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    chk("post-reset flags", 64'({sp_a, dr_a, ea_a, to_a}), 64'd0);
    pop[0] = 1'b1;
    tick();
    pndng[0] = 1'b0; pop[0] = 1'b0;
    tick();
    chk("rearm pass0", 64'(pc_a[0 +: CW]), 64'd1);
    chk("rearm lmax0", 64'(lm_a[0 +: LW]), 64'd2);
    chk("rearm any", 64'(any_a), 64'd0);

`ifdef MESH_HS_DATA_STABLE_EN
    // data changes mid-wait, pop still in window
    data_out[0 +: PS] = 40'h1;
    pndng[0] = 1'b1;
    tick();
    tick();
    data_out[0 +: PS] = 40'h2;
    tick();
    tick();
    pop[0] = 1'b1;
    tick();
    pndng[0] = 1'b0; pop[0] = 1'b0;
    tick();
    chk("data err0", 64'(dt_a[0]), 64'd1);
    chk("data pass0", 64'(pc_a[0 +: CW]), 64'd2);
    chk("data lmax0", 64'(lm_a[0 +: LW]), 64'd4);
    chk("data any", 64'(any_a), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
